// File: rtl/fifo_full_wr_ctrl.sv
// Write-side pointer and full-flag controller for the asynchronous FIFO.
// Produces the memory write address, the Gray write pointer for CDC, and full/fill status.
module fifo_full_wr_ctrl #(
   parameter int ADDR_WIDTH   = 3,
   parameter int AFULL_THRESH = 6
) (
   input  logic                  wclk,
   input  logic                  wrst,
   input  logic                  w_inc,
   input  logic [ADDR_WIDTH:0]   synch_rptr,
   output logic                  wen,
   output logic [ADDR_WIDTH-1:0] waddress,
   output logic [ADDR_WIDTH:0]   write_ptr,
   output logic                  full,
   output logic                  almost_full,
   output logic [ADDR_WIDTH:0]   fill_level,
   output logic                  overflow
);

   localparam int PW = ADDR_WIDTH + 1;

   logic [PW-1:0] r_wbin;
   logic [PW-1:0] r_wgray;
   logic          r_full;
   logic          r_afull;
   logic [PW-1:0] r_fill;
   logic          r_ovf;

   logic [PW-1:0] w_rbin;
   logic [PW-1:0] w_wbin_next;
   logic [PW-1:0] w_wgray_next;
   logic [PW-1:0] w_fill_next;
   logic [PW-1:0] w_full_cmp;
   logic          w_accept;

   // Each binary bit is the XOR of all Gray bits at or above it.
   always_comb begin
      w_rbin = '0;
      for (int i = 0; i < PW; i++) begin
         w_rbin[i] = ^(synch_rptr >> i);
      end
   end

   assign w_accept     = w_inc & ~r_full;
   assign w_wbin_next  = r_wbin + {{(PW-1){1'b0}}, w_accept};
   assign w_wgray_next = w_wbin_next ^ (w_wbin_next >> 1);
   assign w_fill_next  = w_wbin_next - w_rbin;
   // Writer is one full lap ahead: top two Gray bits differ, the rest match.
   assign w_full_cmp   = {~synch_rptr[ADDR_WIDTH:ADDR_WIDTH-1], synch_rptr[ADDR_WIDTH-2:0]};

   always_ff @(posedge wclk) begin
      if (wrst) begin
         r_wbin  <= '0;
         r_wgray <= '0;
         r_full  <= 1'b0;
         r_afull <= 1'b0;
         r_fill  <= '0;
         r_ovf   <= 1'b0;
      end else begin
         r_wbin  <= w_wbin_next;
         r_wgray <= w_wgray_next;
         r_full  <= (w_wgray_next == w_full_cmp);
         r_afull <= (w_fill_next >= PW'(AFULL_THRESH));
         r_fill  <= w_fill_next;
         if (w_inc && r_full) begin
            r_ovf <= 1'b1;
         end
      end
   end

   assign wen         = w_accept;
   assign waddress    = r_wbin[ADDR_WIDTH-1:0];
   assign write_ptr   = r_wgray;
   assign full        = r_full;
   assign almost_full = r_afull;
   assign fill_level  = r_fill;
   assign overflow    = r_ovf;

endmodule

// File: tb/tb_fifo_full_wr_ctrl.sv
// Directed bench for fifo_full_wr_ctrl: a cycle model pushes expected register
// values into a queue as each step is driven; they are popped after the edge.
module tb_fifo_full_wr_ctrl;

   logic       wclk = 1'b0;
   logic       wrst;
   logic       w_inc;
   logic [3:0] synch_rptr;
   logic       wen;
   logic [2:0] waddress;
   logic [3:0] write_ptr;
   logic       full;
   logic       almost_full;
   logic [3:0] fill_level;
   logic       overflow;

   fifo_full_wr_ctrl #(.ADDR_WIDTH(3), .AFULL_THRESH(6)) dut (
      .wclk        (wclk),
      .wrst        (wrst),
      .w_inc       (w_inc),
      .synch_rptr  (synch_rptr),
      .wen         (wen),
      .waddress    (waddress),
      .write_ptr   (write_ptr),
      .full        (full),
      .almost_full (almost_full),
      .fill_level  (fill_level),
      .overflow    (overflow)
   );

   always #5 wclk = ~wclk;

   typedef struct packed {
      logic [3:0] ptr;
      logic       full;
      logic       af;
      logic [3:0] fill;
      logic       ovf;
   } exp_t;

   exp_t q[$];

   int tests = 0;
   int fails = 0;

   logic [3:0] m_wbin = 4'd0;
   logic       m_full = 1'b0;
   logic       m_af   = 1'b0;
   logic [3:0] m_fill = 4'd0;
   logic       m_ovf  = 1'b0;
   logic [3:0] prev_ptr;
   logic [3:0] wrap_seq [16];

   function automatic logic [3:0] g2b(input logic [3:0] g);
      logic [3:0] b;
      b[3] = g[3];
      for (int i = 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
      return b;
   endfunction

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
      tests++;
      assert (obs === exp_v) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
      end
   endtask

   // One clock: drive inputs, check combinational outputs against the model's
   // current state, push the model's next state, then compare after the edge.
   task automatic step(input logic rst, input logic inc, input logic [3:0] rptr);
      exp_t       e;
      exp_t       got;
      logic       acc;
      logic [3:0] nb;
      wrst = rst; w_inc = inc; synch_rptr = rptr;
      #1;
      chk("wen", {7'd0, wen}, {7'd0, inc & ~m_full});
      chk("waddress", {5'd0, waddress}, {5'd0, m_wbin[2:0]});
      if (rst) begin
         m_wbin = 4'd0; m_full = 1'b0; m_af = 1'b0; m_fill = 4'd0; m_ovf = 1'b0;
      end else begin
         acc    = inc & ~m_full;
         nb     = m_wbin + {3'd0, acc};
         m_ovf  = m_ovf | (inc & m_full);
         m_wbin = nb;
         m_fill = nb - g2b(rptr);
         m_full = (m_fill == 4'd8);
         m_af   = (m_fill >= 4'd6);
      end
      e.ptr = m_wbin ^ (m_wbin >> 1);
      e.full = m_full; e.af = m_af; e.fill = m_fill; e.ovf = m_ovf;
      q.push_back(e);
      @(posedge wclk);
      #1;
      tests++;
      assert (q.size() > 0) else begin
         fails++;
         $error("FAIL scoreboard_empty observed=%0d expected=1", q.size());
      end
      if (q.size() > 0) begin
         got = q.pop_front();
         chk("write_ptr",   {4'd0, write_ptr},   {4'd0, got.ptr});
         chk("full",        {7'd0, full},        {7'd0, got.full});
         chk("almost_full", {7'd0, almost_full}, {7'd0, got.af});
         chk("fill_level",  {4'd0, fill_level},  {4'd0, got.fill});
         chk("overflow",    {7'd0, overflow},    {7'd0, got.ovf});
      end
   endtask

   initial begin
      wrap_seq = '{4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111, 4'b0101, 4'b0100, 4'b1100,
                   4'b1101, 4'b1111, 4'b1110, 4'b1010, 4'b1011, 4'b1001, 4'b1000, 4'b0000};
      wrst = 1'b1; w_inc = 1'b1; synch_rptr = 4'd0;
      @(posedge wclk); #1;

      // Reset with writes requested
      step(1'b1, 1'b1, 4'd0);
      step(1'b1, 1'b1, 4'd0);
      chk("reset_ptr", {4'd0, write_ptr}, 8'h00);

      // Fill to full
      for (int i = 0; i < 8; i++) begin
         step(1'b0, 1'b1, 4'd0);
         if (i == 5) chk("afull_at_6", {7'd0, almost_full}, 8'h01);
      end
      chk("full_ptr", {4'd0, write_ptr}, 8'h0C);
      chk("full_fill", {4'd0, fill_level}, 8'h08);
      chk("full_flag", {7'd0, full}, 8'h01);

      // Overflow: rejected writes, sticky flag
      step(1'b0, 1'b1, 4'd0);
      step(1'b0, 1'b1, 4'd0);
      chk("ovf_ptr_hold", {4'd0, write_ptr}, 8'h0C);
      step(1'b0, 1'b0, 4'd0);
      chk("ovf_sticky", {7'd0, overflow}, 8'h01);

      // One read releases full; next write lands at address 0 and refills
      step(1'b0, 1'b0, 4'b0001);
      chk("release_full", {7'd0, full}, 8'h00);
      chk("release_fill", {4'd0, fill_level}, 8'h07);
      chk("refill_addr", {5'd0, waddress}, 8'h00);
      step(1'b0, 1'b1, 4'b0001);
      chk("refull", {7'd0, full}, 8'h01);

      // Wrap: reset, then 16 writes with the reader following one behind
      step(1'b1, 1'b0, 4'd0);
      chk("ovf_cleared", {7'd0, overflow}, 8'h00);
      prev_ptr = write_ptr;
      for (int i = 0; i < 16; i++) begin
         step(1'b0, 1'b1, m_wbin ^ (m_wbin >> 1));
         chk("wrap_seq", {4'd0, write_ptr}, {4'd0, wrap_seq[i]});
         chk("wrap_onebit", 8'($countones(write_ptr ^ prev_ptr)), 8'd1);
         prev_ptr = write_ptr;
      end

      // Simultaneous write and read: fill net-unchanged
      step(1'b0, 1'b1, 4'b0000);
      step(1'b0, 1'b1, 4'b0001);
      chk("simul_fill", {4'd0, fill_level}, 8'h01);

      // Mid-burst reset at fill 5
      step(1'b0, 1'b1, 4'b0001);
      step(1'b0, 1'b1, 4'b0001);
      step(1'b0, 1'b1, 4'b0001);
      step(1'b0, 1'b1, 4'b0001);
      chk("pre_reset_fill", {4'd0, fill_level}, 8'h05);
      step(1'b1, 1'b1, 4'b0001);
      chk("midrst_ptr", {4'd0, write_ptr}, 8'h00);
      chk("midrst_fill", {4'd0, fill_level}, 8'h00);
      step(1'b0, 1'b1, 4'b0000);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
